ifetch_prefetch_queue: RTL and testbench

//  Instruction-fetch front end sitting directly upstream of the single-cycle core's instruction register path.

---
 rtl/ifetch_prefetch_queue.sv | 153 +++++++++++++++
 tb/tb_ifetch_prefetch_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: sequential word fetches, DEPTH-entry FIFO toward the core, redirect flush.
// Optional IFQ_BYPASS_EN forwards a response straight to the core when the queue is empty.
module ifetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [31:0]   fetch_pc, fetch_pc_d;
  logic [CW-1:0] count, count_d;
  logic [CW-1:0] outstanding, outstanding_d;
  logic [CW-1:0] discard, discard_d;
  logic [PW-1:0] wr_ptr, wr_ptr_d;
  logic [PW-1:0] rd_ptr, rd_ptr_d;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic          fifo_nonempty;
  logic          bypass;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_sum;
  logic [31:0]   rsp_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d        = state;
    fetch_pc_d     = fetch_pc;
    count_d        = count;
    outstanding_d  = outstanding;
    discard_d      = discard;
    wr_ptr_d       = wr_ptr;
    rd_ptr_d       = rd_ptr;
    push           = 1'b0;

    fifo_nonempty  = (count != '0);
    credit_sum     = {1'b0, count} + {1'b0, outstanding};
    imem_req_valid = (state == FETCH) && (credit_sum < (CW+1)'(DEPTH)) && !redirect_valid;
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    // Requests are sequential and only live in FETCH, so the oldest in-flight
    // request sits 'outstanding' words behind the next fetch address.
    rsp_pc         = fetch_pc - (32'(outstanding) << 2);

`ifdef IFQ_BYPASS_EN
    bypass = (state == FETCH) && !fifo_nonempty && imem_rsp_valid && !redirect_valid;
`else
    bypass = 1'b0;
`endif

    inst_valid = fifo_nonempty || bypass;
    if (fifo_nonempty) begin
      inst_data = data_mem[rd_ptr];
      inst_pc   = pc_mem[rd_ptr];
    end else if (bypass) begin
      inst_data = imem_rsp_data;
      inst_pc   = rsp_pc;
    end else begin
      inst_data = '0;
      inst_pc   = '0;
    end
    pop = fifo_nonempty && inst_ready;

    case (state)
      IDLE: state_d = FETCH;
      FETCH: begin
        push          = imem_rsp_valid && !(bypass && inst_ready);
        outstanding_d = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
        if (req_fire) fetch_pc_d = fetch_pc + 32'd4;
      end
      DRAIN: begin
        if (imem_rsp_valid) begin
          discard_d = discard - 1'b1;
          if (discard == CW'(1)) state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    count_d  = count + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr + PW'(push);
    rd_ptr_d = rd_ptr + PW'(pop);

    if (redirect_valid) begin
      push          = 1'b0;
      fetch_pc_d    = redirect_pc & 32'hFFFF_FFFC;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      outstanding_d = '0;
      case (state)
        FETCH:   discard_d = outstanding - CW'(imem_rsp_valid);
        DRAIN:   discard_d = discard - CW'(imem_rsp_valid);
        default: discard_d = '0;
      endcase
      state_d = (discard_d != '0) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      fetch_pc    <= fetch_pc_d;
      count       <= count_d;
      outstanding <= outstanding_d;
      discard     <= discard_d;
      wr_ptr      <= wr_ptr_d;
      rd_ptr      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      data_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Directed bench for ifetch_prefetch_queue with an in-order variable-latency memory model.
module tb_ifetch_prefetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, w_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr, w_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid, w_inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data, w_inst_data;
  logic [31:0] inst_pc, w_inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int unsigned lat = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_log[$], pop_pc[$], pop_data[$], w_req_log[$], w_pop_pc[$];

  always #5 clk = ~clk;

  ifetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Runs in lockstep with dut (same inputs), only the start address differs.
  ifetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(w_inst_valid), .inst_ready(inst_ready), .inst_data(w_inst_data), .inst_pc(w_inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic clear_logs();
    req_log.delete(); pop_pc.delete(); pop_data.delete(); w_req_log.delete(); w_pop_pc.delete();
  endtask

  // One clock: log handshakes mid-cycle, then advance the memory model after the edge.
  task automatic step();
    logic        hs;
    logic [31:0] a;
    @(negedge clk);
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    if (hs) req_log.push_back(a);
    if (w_req_valid && imem_req_ready) w_req_log.push_back(w_req_addr);
    if (inst_valid && inst_ready) begin pop_pc.push_back(inst_pc); pop_data.push_back(inst_data); end
    if (w_inst_valid && inst_ready) w_pop_pc.push_back(w_inst_pc);
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      pend_addr.delete(); pend_due.delete();
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    end else begin
      if (hs) begin pend_addr.push_back(a); pend_due.push_back(cyc + int'(lat) - 1); end
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1; lat = 1;
    step(); step();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h0) begin n_err++; $display("FAIL rst_req_addr got %h want 00000000", imem_req_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid got %b want 0", inst_valid); end
    n_cmp++; if (inst_data !== 32'h0) begin n_err++; $display("FAIL rst_inst_data got %h want 0", inst_data); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_inst_pc got %h want 0", inst_pc); end
    n_cmp++; if (w_req_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL rst_w_req_addr got %h want fffffff8", w_req_addr); end
    reset = 1'b0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL idle_no_req got %b want 0", imem_req_valid); end
    step();
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL first_req_valid got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h0) begin n_err++; $display("FAIL first_req_addr got %h want 0", imem_req_addr); end
  endtask

  task automatic test_stream();
    inst_ready = 1'b1; lat = 1; clear_logs();
    for (int i = 0; i < 16; i++) begin
      imem_req_ready = (i == 5 || i == 6) ? 1'b0 : 1'b1;
      step();
    end
    imem_req_ready = 1'b1;
    n_cmp++; if (req_log.size() < 8) begin n_err++; $display("FAIL stream_req_count got %0d want >=8", req_log.size()); end
    n_cmp++; if (pop_pc.size() < 8) begin n_err++; $display("FAIL stream_pop_count got %0d want >=8", pop_pc.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < req_log.size()) begin
        n_cmp++; if (req_log[i] !== 32'(4*i)) begin n_err++; $display("FAIL stream_req[%0d] got %h want %h", i, req_log[i], 32'(4*i)); end
      end
      if (i < pop_pc.size()) begin
        n_cmp++; if (pop_pc[i] !== 32'(4*i)) begin n_err++; $display("FAIL stream_pc[%0d] got %h want %h", i, pop_pc[i], 32'(4*i)); end
        n_cmp++; if (pop_data[i] !== mem_word(32'(4*i))) begin n_err++; $display("FAIL stream_data[%0d] got %h want %h", i, pop_data[i], mem_word(32'(4*i))); end
      end
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    inst_ready = 1'b0; lat = 1; clear_logs();
    repeat (10) step();
    n_cmp++; if (req_log.size() != 4) begin n_err++; $display("FAIL bp_req_count got %0d want 4", req_log.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < req_log.size()) begin
        n_cmp++; if (req_log[i] !== 32'(4*i)) begin n_err++; $display("FAIL bp_req[%0d] got %h want %h", i, req_log[i], 32'(4*i)); end
      end
    end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_req_stalled got %b want 0", imem_req_valid); end
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL bp_inst_valid got %b want 1", inst_valid); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL bp_inst_pc got %h want 0", inst_pc); end
    inst_ready = 1'b1;
    repeat (10) step();
    n_cmp++; if (req_log.size() < 5) begin n_err++; $display("FAIL bp_resume_count got %0d want >=5", req_log.size()); end
    else begin
      n_cmp++; if (req_log[4] !== 32'h10) begin n_err++; $display("FAIL bp_resume_addr got %h want 00000010", req_log[4]); end
    end
    for (int i = 0; i < 5; i++) begin
      if (i < pop_pc.size()) begin
        n_cmp++; if (pop_pc[i] !== 32'(4*i)) begin n_err++; $display("FAIL bp_pc[%0d] got %h want %h", i, pop_pc[i], 32'(4*i)); end
      end else begin
        n_cmp++; n_err++; $display("FAIL bp_pc[%0d] got none want %h", i, 32'(4*i));
      end
    end
  endtask

  task automatic test_redirect();
    test_reset();
    lat = 3; inst_ready = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rd_req_suppressed got %b want 0", imem_req_valid); end
    step();
    redirect_valid = 1'b0; clear_logs();
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rd_flushed got %b want 0", inst_valid); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rd_drain_req0 got %b want 0", imem_req_valid); end
    step();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rd_drain_req1 got %b want 0", imem_req_valid); end
    step();
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL rd_restart_valid got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h40) begin n_err++; $display("FAIL rd_restart_addr got %h want 00000040", imem_req_addr); end
    repeat (10) step();
    n_cmp++; if (pop_pc.size() < 2) begin n_err++; $display("FAIL rd_pop_count got %0d want >=2", pop_pc.size()); end
    else begin
      n_cmp++; if (pop_pc[0] !== 32'h40) begin n_err++; $display("FAIL rd_pc0 got %h want 00000040", pop_pc[0]); end
      n_cmp++; if (pop_data[0] !== mem_word(32'h40)) begin n_err++; $display("FAIL rd_data0 got %h want %h", pop_data[0], mem_word(32'h40)); end
      n_cmp++; if (pop_pc[1] !== 32'h44) begin n_err++; $display("FAIL rd_pc1 got %h want 00000044", pop_pc[1]); end
    end
  endtask

  task automatic test_redirect_pop();
    test_reset();
    lat = 1; inst_ready = 1'b0; clear_logs();
    step(); step();
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103;
    #1;
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL rp_head_valid got %b want 1", inst_valid); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rp_head_pc got %h want 0", inst_pc); end
    step();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (pop_pc.size() != 1) begin n_err++; $display("FAIL rp_pop_count got %0d want 1", pop_pc.size()); end
    else begin
      n_cmp++; if (pop_pc[0] !== 32'h0) begin n_err++; $display("FAIL rp_pop_pc got %h want 0", pop_pc[0]); end
      n_cmp++; if (pop_data[0] !== mem_word(32'h0)) begin n_err++; $display("FAIL rp_pop_data got %h want %h", pop_data[0], mem_word(32'h0)); end
    end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rp_flushed got %b want 0", inst_valid); end
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL rp_restart_valid got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h100) begin n_err++; $display("FAIL rp_restart_addr got %h want 00000100", imem_req_addr); end
    clear_logs();
    repeat (6) step();
    n_cmp++; if (pop_pc.size() < 1) begin n_err++; $display("FAIL rp_new_count got %0d want >=1", pop_pc.size()); end
    else begin
      n_cmp++; if (pop_pc[0] !== 32'h100) begin n_err++; $display("FAIL rp_new_pc got %h want 00000100", pop_pc[0]); end
      n_cmp++; if (pop_data[0] !== mem_word(32'h100)) begin n_err++; $display("FAIL rp_new_data got %h want %h", pop_data[0], mem_word(32'h100)); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hFFFF_FFF8; exp_w[1] = 32'hFFFF_FFFC; exp_w[2] = 32'h0000_0000;
    test_reset();
    inst_ready = 1'b1; lat = 1; clear_logs();
    repeat (8) step();
    for (int i = 0; i < 3; i++) begin
      if (i < w_req_log.size()) begin
        n_cmp++; if (w_req_log[i] !== exp_w[i]) begin n_err++; $display("FAIL wrap_req[%0d] got %h want %h", i, w_req_log[i], exp_w[i]); end
      end else begin
        n_cmp++; n_err++; $display("FAIL wrap_req[%0d] got none want %h", i, exp_w[i]);
      end
      if (i < w_pop_pc.size()) begin
        n_cmp++; if (w_pop_pc[i] !== exp_w[i]) begin n_err++; $display("FAIL wrap_pc[%0d] got %h want %h", i, w_pop_pc[i], exp_w[i]); end
      end else begin
        n_cmp++; n_err++; $display("FAIL wrap_pc[%0d] got none want %h", i, exp_w[i]);
      end
    end
  endtask

  task automatic test_latency();
    test_reset();
    lat = 1; inst_ready = 1'b0;
    step();
    n_cmp++; if (inst_valid !== BYP) begin n_err++; $display("FAIL lat_same_cycle_valid got %b want %b", inst_valid, BYP); end
    n_cmp++; if (inst_data !== (BYP ? mem_word(32'h0) : 32'h0)) begin n_err++; $display("FAIL lat_same_cycle_data got %h want %h", inst_data, (BYP ? mem_word(32'h0) : 32'h0)); end
    step();
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL lat_next_valid got %b want 1", inst_valid); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL lat_next_pc got %h want 0", inst_pc); end
    n_cmp++; if (inst_data !== mem_word(32'h0)) begin n_err++; $display("FAIL lat_next_data got %h want %h", inst_data, mem_word(32'h0)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
